// File: rtl/wci_boot_sequencer.sv
// WCI master-side boot sequencer.
// Walks a WCI slave worker from reset to operating by issuing a fixed
// script on the S0 port: Initialize, NUM_CFG config writes, AfterConfig, Start.
// Config write address/data come from an external table addressed by cfg_index_o.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | out of reset, waiting for go
//  ISSUE  | command for current step ready, waiting for SThreadBusy=0
//  WAIT   | command issued (MCmd on first cycle only), waiting for SResp
//  DONE   | whole script answered with DVA; done sticky until next go
//  ERROR  | FAIL/ERR/timeout seen; error info sticky until next go
module wci_boot_sequencer #(
    parameter int NUM_CFG = 4,
    parameter int TIMEOUT = 255,
    parameter int IDX_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               go_i,
    output logic [IDX_W-1:0]   cfg_index_o,
    input  logic [19:0]        cfg_addr_i,
    input  logic [31:0]        cfg_data_i,
    output logic [2:0]         wciS0_MCmd_o,
    output logic               wciS0_MAddrSpace_o,
    output logic [3:0]         wciS0_MByteEn_o,
    output logic [19:0]        wciS0_MAddr_o,
    output logic [31:0]        wciS0_MData_o,
    input  logic [1:0]         wciS0_SResp_i,
    input  logic [31:0]        wciS0_SData_i,
    input  logic               wciS0_SThreadBusy_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic [1:0]         err_code_o,
    output logic [IDX_W+1:0]   err_step_o,
    output logic [31:0]        last_rdata_o
);

    localparam int SW    = IDX_W + 2;
    localparam int TMR_W = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_READ  = 3'd2;

    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;
    localparam logic [1:0] RESP_FAIL = 2'd2;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    localparam logic [1:0] EC_NONE    = 2'd0;
    localparam logic [1:0] EC_FAIL    = 2'd1;
    localparam logic [1:0] EC_ERR     = 2'd2;
    localparam logic [1:0] EC_TIMEOUT = 2'd3;

    localparam logic [19:0] ADDR_INITIALIZE  = 20'h00000;
    localparam logic [19:0] ADDR_AFTERCONFIG = 20'h00018;
    localparam logic [19:0] ADDR_START       = 20'h00004;

    localparam logic [SW-1:0]    STEP_CFG_LAST = SW'(NUM_CFG);
    localparam logic [SW-1:0]    STEP_AFTER    = SW'(NUM_CFG + 1);
    localparam logic [SW-1:0]    STEP_LAST     = SW'(NUM_CFG + 2);
    localparam logic [TMR_W-1:0] TIMER_LOAD    = TMR_W'(TIMEOUT);

    logic [2:0]       state_q,  state_d;
    logic [SW-1:0]    step_q,   step_d;
    logic [TMR_W-1:0] timer_q,  timer_d;
    logic [IDX_W-1:0] index_q,  index_d;
    logic [2:0]       mcmd_q,   mcmd_d;
    logic             space_q,  space_d;
    logic [3:0]       byteen_q, byteen_d;
    logic [19:0]      addr_q,   addr_d;
    logic [31:0]      data_q,   data_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             error_q,  error_d;
    logic [1:0]       ecode_q,  ecode_d;
    logic [SW-1:0]    estep_q,  estep_d;
    logic [31:0]      rdata_q,  rdata_d;

    logic             step_is_cfg;
    logic             next_is_cfg;
    logic [19:0]      ctl_addr;

    // Decode the current step into its transaction type and control address.
    always_comb begin
        step_is_cfg = (step_q != '0) && (step_q <= STEP_CFG_LAST);
        next_is_cfg = (step_q < STEP_CFG_LAST);
        if (step_q == '0) begin
            ctl_addr = ADDR_INITIALIZE;
        end else if (step_q == STEP_AFTER) begin
            ctl_addr = ADDR_AFTERCONFIG;
        end else begin
            ctl_addr = ADDR_START;
        end
    end

    // Next-state and next-output logic for the script FSM.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        timer_d  = timer_q;
        index_d  = index_q;
        mcmd_d   = mcmd_q;
        space_d  = space_q;
        byteen_d = byteen_q;
        addr_d   = addr_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = done_q;
        error_d  = error_q;
        ecode_d  = ecode_q;
        estep_d  = estep_q;
        rdata_d  = rdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (go_i) begin
                    state_d = S_ISSUE;
                    step_d  = '0;
                    index_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    ecode_d = EC_NONE;
                    estep_d = '0;
                end
            end

            S_ISSUE: begin
                // Hold off without timing out while the slave is busy.
                if (!wciS0_SThreadBusy_i) begin
                    state_d  = S_WAIT;
                    timer_d  = TIMER_LOAD;
                    byteen_d = 4'hF;
                    if (step_is_cfg) begin
                        mcmd_d  = CMD_WRITE;
                        space_d = 1'b1;
                        addr_d  = cfg_addr_i;
                        data_d  = cfg_data_i;
                    end else begin
                        mcmd_d  = CMD_READ;
                        space_d = 1'b0;
                        addr_d  = ctl_addr;
                        data_d  = '0;
                    end
                end
            end

            S_WAIT: begin
                // MCmd is a one-cycle pulse; address/data/space hold.
                mcmd_d = CMD_IDLE;
                case (wciS0_SResp_i)
                    RESP_DVA: begin
                        if (!step_is_cfg) begin
                            rdata_d = wciS0_SData_i;
                        end
                        if (step_q == STEP_LAST) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_ISSUE;
                            step_d  = step_q + 1'b1;
                            if (next_is_cfg) begin
                                index_d = step_q[IDX_W-1:0];
                            end
                        end
                    end
                    RESP_FAIL, RESP_ERR: begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        ecode_d = (wciS0_SResp_i == RESP_FAIL) ? EC_FAIL : EC_ERR;
                        estep_d = step_q;
                    end
                    default: begin
                        // Timer reads 1 on the last in-time WAIT cycle.
                        if (timer_q <= TMR_W'(1)) begin
                            state_d = S_ERROR;
                            error_d = 1'b1;
                            busy_d  = 1'b0;
                            ecode_d = EC_TIMEOUT;
                            estep_d = step_q;
                        end else begin
                            timer_d = timer_q - 1'b1;
                        end
                    end
                endcase
            end

            default: begin
                state_d = S_IDLE;
                mcmd_d  = CMD_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset drops any in-flight command.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            timer_q  <= '0;
            index_q  <= '0;
            mcmd_q   <= CMD_IDLE;
            space_q  <= 1'b0;
            byteen_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            ecode_q  <= EC_NONE;
            estep_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            timer_q  <= timer_d;
            index_q  <= index_d;
            mcmd_q   <= mcmd_d;
            space_q  <= space_d;
            byteen_q <= byteen_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            ecode_q  <= ecode_d;
            estep_q  <= estep_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cfg_index_o        = index_q;
    assign wciS0_MCmd_o       = mcmd_q;
    assign wciS0_MAddrSpace_o = space_q;
    assign wciS0_MByteEn_o    = byteen_q;
    assign wciS0_MAddr_o      = addr_q;
    assign wciS0_MData_o      = data_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign error_o            = error_q;
    assign err_code_o         = ecode_q;
    assign err_step_o         = estep_q;
    assign last_rdata_o       = rdata_q;

endmodule

// File: tb/tb_wci_boot_sequencer.sv
// Directed bench for wci_boot_sequencer (NUM_CFG=2, TIMEOUT=8).
module tb_wci_boot_sequencer;

    localparam int IDX_W = 8;

    logic              clk;
    logic              rst_n;
    logic              go;
    logic [IDX_W-1:0]  cfg_index;
    logic [19:0]       cfg_addr;
    logic [31:0]       cfg_data;
    logic [2:0]        mcmd;
    logic              mspace;
    logic [3:0]        mbyteen;
    logic [19:0]       maddr;
    logic [31:0]       mdata;
    logic [1:0]        sresp;
    logic [31:0]       sdata;
    logic              sthreadbusy;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [IDX_W+1:0]  err_step;
    logic [31:0]       last_rdata;

    int checks = 0;
    int errors = 0;

    wci_boot_sequencer #(.NUM_CFG(2), .TIMEOUT(8), .IDX_W(IDX_W)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .go_i                (go),
        .cfg_index_o         (cfg_index),
        .cfg_addr_i          (cfg_addr),
        .cfg_data_i          (cfg_data),
        .wciS0_MCmd_o        (mcmd),
        .wciS0_MAddrSpace_o  (mspace),
        .wciS0_MByteEn_o     (mbyteen),
        .wciS0_MAddr_o       (maddr),
        .wciS0_MData_o       (mdata),
        .wciS0_SResp_i       (sresp),
        .wciS0_SData_i       (sdata),
        .wciS0_SThreadBusy_i (sthreadbusy),
        .busy_o              (busy),
        .done_o              (done),
        .error_o             (error),
        .err_code_o          (err_code),
        .err_step_o          (err_step),
        .last_rdata_o        (last_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Config table seen by the sequencer.
    always_comb begin
        cfg_addr = 20'h0;
        cfg_data = 32'h0;
        case (cfg_index)
            8'd0: begin cfg_addr = 20'h00010; cfg_data = 32'hDEADBEEF; end
            8'd1: begin cfg_addr = 20'h00020; cfg_data = 32'h12345678; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mcmd(input int max_cycles);
        int n;
        n = 0;
        while (mcmd == 3'd0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("mcmd_seen", 64'(mcmd != 3'd0), 64'd1);
    endtask

    // Wait for the command, check its fields, answer on WAIT cycle resp_cycle.
    task automatic do_step(input string tag, input logic [2:0] ecmd, input logic espace,
                           input logic [19:0] eaddr, input logic [31:0] edata,
                           input logic [1:0] resp, input logic [31:0] rd, input int resp_cycle);
        wait_mcmd(20);
        check({tag, "_cmd"},   64'(mcmd),    64'(ecmd));
        check({tag, "_space"}, 64'(mspace),  64'(espace));
        check({tag, "_addr"},  64'(maddr),   64'(eaddr));
        check({tag, "_data"},  64'(mdata),   64'(edata));
        check({tag, "_be"},    64'(mbyteen), 64'hF);
        for (int c = 1; c < resp_cycle; c++) begin
            tick();
            if (c == 1) check({tag, "_pulse"}, 64'(mcmd), 64'd0);
        end
        sresp = resp;
        sdata = rd;
        tick();
        sresp = 2'd0;
        sdata = 32'h0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic run_full(input string tag);
        pulse_go();
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_idx0"}, 64'(cfg_index), 64'd0);
        do_step({tag, "_s0"}, 3'd2, 1'b0, 20'h00000, 32'h0,        2'd1, 32'h11110000, 2);
        check({tag, "_rd0"}, 64'(last_rdata), 64'h11110000);
        do_step({tag, "_s1"}, 3'd1, 1'b1, 20'h00010, 32'hDEADBEEF, 2'd1, 32'hFFFFFFFF, 2);
        check({tag, "_wr_nocap"}, 64'(last_rdata), 64'h11110000);
        do_step({tag, "_s2"}, 3'd1, 1'b1, 20'h00020, 32'h12345678, 2'd1, 32'h0, 2);
        do_step({tag, "_s3"}, 3'd2, 1'b0, 20'h00018, 32'h0,        2'd1, 32'h22220000, 2);
        check({tag, "_rd3"}, 64'(last_rdata), 64'h22220000);
        do_step({tag, "_s4"}, 3'd2, 1'b0, 20'h00004, 32'h0,        2'd1, 32'hC0DE0001, 2);
        check({tag, "_rd4"},   64'(last_rdata), 64'hC0DE0001);
        check({tag, "_done"},  64'(done),       64'd1);
        check({tag, "_busy0"}, 64'(busy),       64'd0);
        check({tag, "_err"},   64'(error),      64'd0);
        check({tag, "_ecode"}, 64'(err_code),   64'd0);
        check({tag, "_mcmd0"}, 64'(mcmd),       64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        rst_n = 1'b0;
        go = 1'b0;
        sresp = 2'd0;
        sdata = 32'h0;
        sthreadbusy = 1'b0;
        tick();
        tick();
        check("rst_mcmd",  64'(mcmd),       64'd0);
        check("rst_busy",  64'(busy),       64'd0);
        check("rst_done",  64'(done),       64'd0);
        check("rst_error", 64'(error),      64'd0);
        check("rst_idx",   64'(cfg_index),  64'd0);
        check("rst_rdata", 64'(last_rdata), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        // Full script with DVA one cycle after each MCmd.
        run_full("run1");

        // SThreadBusy held for 10 cycles after go.
        sthreadbusy = 1'b1;
        pulse_go();
        check("tb_done_clr", 64'(done), 64'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (mcmd != 3'd0) bad++;
            tick();
        end
        check("tb_mcmd_held", 64'(bad), 64'd0);
        check("tb_no_timeout", 64'(error), 64'd0);
        sthreadbusy = 1'b0;
        tick();
        check("tb_first_mcmd", 64'(mcmd), 64'd2);
        do_step("tb_s0", 3'd2, 1'b0, 20'h00000, 32'h0,        2'd1, 32'h0, 2);
        do_step("tb_s1", 3'd1, 1'b1, 20'h00010, 32'hDEADBEEF, 2'd1, 32'h0, 2);
        // Second config write answered with FAIL.
        do_step("tb_s2", 3'd1, 1'b1, 20'h00020, 32'h12345678, 2'd2, 32'h0, 2);
        check("fail_error", 64'(error),    64'd1);
        check("fail_code",  64'(err_code), 64'd1);
        check("fail_step",  64'(err_step), 64'd2);
        check("fail_busy",  64'(busy),     64'd0);
        check("fail_done",  64'(done),     64'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (mcmd != 3'd0) bad++;
            tick();
        end
        check("fail_no_mcmd", 64'(bad), 64'd0);
        run_full("run2");

        // Timeout: no response to Initialize.
        pulse_go();
        wait_mcmd(20);
        check("to_cmd", 64'(mcmd), 64'd2);
        for (int c = 1; c < 8; c++) tick();
        check("to_wait8_noerr", 64'(error), 64'd0);
        tick();
        check("to_error", 64'(error),    64'd1);
        check("to_code",  64'(err_code), 64'd3);
        check("to_step",  64'(err_step), 64'd0);
        check("to_busy",  64'(busy),     64'd0);

        // DVA on WAIT cycle 8 is still in time.
        pulse_go();
        check("late_clr_code", 64'(err_code), 64'd0);
        do_step("late_s0", 3'd2, 1'b0, 20'h00000, 32'h0, 2'd1, 32'hABCD0000, 8);
        check("late_noerr", 64'(error),      64'd0);
        check("late_busy",  64'(busy),       64'd1);
        check("late_rdata", 64'(last_rdata), 64'hABCD0000);
        do_step("late_s1", 3'd1, 1'b1, 20'h00010, 32'hDEADBEEF, 2'd1, 32'h0, 2);
        do_step("late_s2", 3'd1, 1'b1, 20'h00020, 32'h12345678, 2'd1, 32'h0, 2);

        // Reset during WAIT of step 3.
        wait_mcmd(20);
        check("rw_addr", 64'(maddr), 64'h00018);
        tick();
        rst_n = 1'b0;
        #1;
        check("rw_mcmd",  64'(mcmd),       64'd0);
        check("rw_busy",  64'(busy),       64'd0);
        check("rw_error", 64'(error),      64'd0);
        check("rw_done",  64'(done),       64'd0);
        check("rw_code",  64'(err_code),   64'd0);
        check("rw_estep", 64'(err_step),   64'd0);
        check("rw_idx",   64'(cfg_index),  64'd0);
        check("rw_rdata", 64'(last_rdata), 64'd0);
        check("rw_maddr", 64'(maddr),      64'd0);
        tick();
        rst_n = 1'b1;
        sresp = 2'd1;
        sdata = 32'h55555555;
        tick();
        sresp = 2'd0;
        sdata = 32'h0;
        check("late_dva_busy",  64'(busy),       64'd0);
        check("late_dva_done",  64'(done),       64'd0);
        check("late_dva_rdata", 64'(last_rdata), 64'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (mcmd != 3'd0 || busy) bad++;
            tick();
        end
        check("idle_after_rst", 64'(bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wci_boot_sequencer.md
Name: wci_boot_sequencer

Overview:
- Master-side controller that brings a WCI-slave worker (e.g. the 32B delay worker) from reset to operating.
- Issues a fixed control/config script over the WCI S0 port: Initialize, NUM_CFG config writes, AfterConfig, Start.
- Write address/data for each config step come from an external table indexed by the sequencer.
- Sits beside the worker in top-level test wrappers and replaces free-running stimulus on the WCI MData/MCmd inputs.

Parameters:
NUM_CFG, 4, number of config-space writes in the script (1..255)
TIMEOUT, 255, maximum cycles to wait for a response per transaction (1..65535)
IDX_W, 8, width of cfg_index

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
go  in  1  start script; sampled in IDLE, DONE and ERROR only
cfg_index  out  IDX_W  current config table entry, 0..NUM_CFG-1
cfg_addr  in  20  config byte address for cfg_index; combinational table output
cfg_data  in  32  config write data for cfg_index
wciS0_MCmd  out  3  0=idle, 1=write, 2=read
wciS0_MAddrSpace  out  1  0=control, 1=config
wciS0_MByteEn  out  4  byte enables
wciS0_MAddr  out  20  byte address
wciS0_MData  out  32  write data
wciS0_SResp  in  2  0=NULL, 1=DVA, 2=FAIL, 3=ERR
wciS0_SData  in  32  read data
wciS0_SThreadBusy  in  1  slave cannot accept a command
busy  out  1  script in progress
done  out  1  script completed; sticky until next go or reset
error  out  1  script aborted; sticky until next go or reset
err_code  out  2  0=none, 1=FAIL, 2=ERR, 3=timeout
err_step  out  IDX_W+2  step number at which the error occurred
last_rdata  out  32  SData captured on the last DVA read

Behaviour:
- Reset (async assert, sync release) gives state IDLE and clears all outputs to 0, including MCmd=0 and cfg_index=0. Reset mid-transaction drops MCmd on assertion; the in-flight response is ignored.
- States: IDLE, ISSUE, WAIT, DONE, ERROR. All outputs are registered.
- Script steps, numbered from 0:
  - Step 0: control read, Initialize, MAddr=0x00000.
  - Steps 1..NUM_CFG: config write, MAddr=cfg_addr, MData=cfg_data, MByteEn=4'hF, cfg_index=step-1.
  - Step NUM_CFG+1: control read, AfterConfig, MAddr=0x00018.
  - Step NUM_CFG+2: control read, Start, MAddr=0x00004.
- Control reads drive MAddrSpace=0, MByteEn=4'hF, MData=0.
- IDLE/DONE/ERROR with go=1: next edge enters ISSUE with step=0, busy=1, done=0, error=0, err_code=0, cfg_index=0.
- ISSUE:
  - If SThreadBusy=1, stay; MCmd remains 0 and there is no timeout.
  - If SThreadBusy=0, on the edge register the command fields, set MCmd=write or read, clear the timeout counter, enter WAIT.
  - cfg_addr/cfg_data are sampled on this edge. cfg_index is valid at least one cycle earlier.
- WAIT:
  - MCmd is high for exactly the first WAIT cycle, then 0. Address, data and space hold until the step ends.
  - SResp is sampled every WAIT cycle, including the MCmd cycle.
  - DVA: on a read, capture last_rdata=SData. If the step is the last, enter DONE (done=1, busy=0); otherwise step+1 and return to ISSUE.
  - FAIL or ERR: enter ERROR with error=1, busy=0, err_code=1 or 2, err_step=step.
  - No response within TIMEOUT WAIT cycles: enter ERROR with err_code=3. A response arriving on cycle TIMEOUT still counts as in time.
- go while busy is ignored. In DONE/ERROR, a go restarts the script from step 0.
- A response seen outside WAIT is ignored.
- step counter width is IDX_W+2; it never wraps for legal NUM_CFG.

Test Plan:
- NUM_CFG=2, SThreadBusy=0, slave returns DVA 1 cycle after each MCmd, table {0x00010:0xDEADBEEF, 0x00020:0x12345678} -> 5 single-cycle MCmd pulses in order: read 0x00000 sp0, write 0x00010/0xDEADBEEF sp1, write 0x00020/0x12345678 sp1, read 0x00018 sp0, read 0x00004 sp0; then done=1, busy=0, err_code=0.
- Start read returns DVA with SData=0xC0DE0001 -> last_rdata=0xC0DE0001 on the edge the DVA is sampled.
- SThreadBusy held 1 for 10 cycles after go -> MCmd stays 0 for those cycles; first MCmd appears the cycle after busy drops; no timeout.
- Second config write answered with FAIL -> error=1, err_code=1, err_step=2, no further MCmd; then go -> script restarts at step 0 and reaches done=1.
- TIMEOUT=8, slave never responds to Initialize -> error=1, err_code=3, err_step=0 after 8 WAIT cycles. Repeat with a DVA on WAIT cycle 8 -> proceeds to step 1.
- Assert reset during WAIT of step 3 -> MCmd=0 and all status 0 immediately; a late DVA after release is ignored and the block stays in IDLE.
